calc_entry_ctrl: RTL and testbench
==================================

CALC_ENTRY_CTRL -- requirements
Module: calc_entry_ctrl

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have key_valid, input, 1, one-cycle pulse per debounced key press.
REQ-004 SHALL have key_code, input, 5:
- 0x00-0x0F hex digit
- 0x10 ENTER
- 0x11 CLEAR
- 0x12-0x16 operator keys
REQ-005 SHALL have dato, input, 16, current value of the operand shift register.
REQ-006 SHALL have alu_done, input, 1, ALU result-valid level.
REQ-007 SHALL have shift_en, output, 1, shift-register load strobe.
REQ-008 SHALL have shift_clr, output, 1, synchronous clear to the shift register.
REQ-009 SHALL have digit_out, output, 5, equal to key_code, wired to the shift-register data input.
REQ-010 SHALL have opa and opb, outputs, 16 each, latched operands.
REQ-011 SHALL have opcode, output, 3, latched operation (key_code-0x12).
REQ-012 SHALL have alu_start, output, 1, one-cycle ALU start pulse.
REQ-013 SHALL have state, output, 3, current FSM state.
REQ-014 SHALL have digit_cnt, output, 3, number of digits in the current operand.
REQ-015 SHALL have err, output, 1, sticky ALU timeout flag.

Function
REQ-016 SHALL implement states ENTER_A, ENTER_B, ENTER_OP, EXEC, SHOW.
REQ-017 SHALL drive shift_en and shift_clr combinationally in the same cycle as key_valid; all other outputs SHALL be registered.
REQ-018 SHALL, on a digit in ENTER_A/ENTER_B with digit_cnt<4, assert shift_en for that cycle and increment digit_cnt; with digit_cnt==4, ignore the digit (no shift_en, count unchanged).
REQ-019 SHALL, on ENTER in ENTER_A, latch opa<=dato (pre-edge value), assert shift_clr, zero digit_cnt, and go to ENTER_B; zero digits yields opa=0.
REQ-020 SHALL, on ENTER in ENTER_B, latch opb<=dato, assert shift_clr, zero digit_cnt, and go to ENTER_OP.
REQ-021 SHALL, on an operator key in ENTER_OP, latch opcode and go to EXEC; digits and ENTER in ENTER_OP are ignored.
REQ-022 SHALL assert alu_start only in the first EXEC cycle, for exactly one cycle.
REQ-023 SHALL sample alu_done in every EXEC cycle, including the first; alu_done=1 SHALL move to SHOW on the next edge.
REQ-024 SHALL count EXEC cycles with a 5-bit timeout counter; when 16 cycles elapse without alu_done, SHALL set err=1 and go to SHOW.
REQ-025 SHALL ignore all keys in EXEC except CLEAR.
REQ-026 SHALL, in SHOW, go to ENTER_A on ENTER (opa/opb/opcode held; err cleared); other non-CLEAR keys are ignored.
REQ-027 SHALL give CLEAR highest priority in every state:
- shift_clr=1
- digit_cnt, opa, opb, opcode and err zeroed
- next state ENTER_A
- any pending alu_start suppressed
REQ-028 SHALL ignore key codes 0x17-0x1F in every state.

Reset
REQ-029 SHALL, with rst low, immediately force state=ENTER_A, opa=opb=0, opcode=0, digit_cnt=0, err=0, alu_start=0, timeout counter=0.
REQ-030 SHALL, while rst is low, hold shift_en=0 and shift_clr=1.
REQ-031 SHALL abort an EXEC in progress when reset is asserted, with no alu_start after release.

Structure
REQ-032 SHALL take the state enum, key-code constants, opcode enum and timeout limit (16) from shared package calc_pkg.
REQ-033 SHALL be a single module; no sub-module is needed.

Verification
REQ-034 Keys 1,2,A,F,ENTER -> four shift_en pulses; opa=0x12AF; state ENTER_B; shift_clr=1 in the ENTER cycle.
REQ-035 Five digits 1,2,3,4,5 in ENTER_A -> fifth produces no shift_en; digit_cnt stays 4.
REQ-036 opa=0x0003, opb=0x0004, key 0x12 -> alu_start high exactly 1 cycle; alu_done after 3 cycles -> SHOW; err=0.
REQ-037 alu_done held 0 in EXEC -> SHOW after 16 cycles; err=1.
REQ-038 CLEAR during ENTER_B with digit_cnt=2 -> ENTER_A; opa=0; digit_cnt=0; shift_clr=1.
REQ-039 rst pulled low mid-EXEC -> all outputs at reset values with no clock edge; no alu_start after release.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator key-entry controller.
// Covers the FSM states, key codes, opcodes and the ALU timeout limit.
package calc_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] MAX_DIGITS    = 3'd4;
  localparam logic [4:0] TIMEOUT_LIMIT = 5'd16;

  localparam logic [4:0] KEY_DIGIT_MAX = 5'h0F;
  localparam logic [4:0] KEY_ENTER     = 5'h10;
  localparam logic [4:0] KEY_CLEAR     = 5'h11;
  localparam logic [4:0] KEY_OP_FIRST  = 5'h12;
  localparam logic [4:0] KEY_OP_LAST   = 5'h16;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_ENTER_OP = 3'd2,
    ST_EXEC     = 3'd3,
    ST_SHOW     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_K0 = 3'd0,
    OP_K1 = 3'd1,
    OP_K2 = 3'd2,
    OP_K3 = 3'd3,
    OP_K4 = 3'd4
  } opcode_t;

  function automatic logic is_digit(input logic [4:0] k);
    return k <= KEY_DIGIT_MAX;
  endfunction

  function automatic logic is_op(input logic [4:0] k);
    return (k >= KEY_OP_FIRST) && (k <= KEY_OP_LAST);
  endfunction

  // Operator keys map onto opcodes by their offset from the first operator key.
  function automatic opcode_t key_to_opcode(input logic [4:0] k);
    return opcode_t'(3'(k - KEY_OP_FIRST));
  endfunction

endpackage

// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller: collects two hex operands and an operator,
// launches the ALU, waits for its result (with timeout) and shows it.
module calc_entry_ctrl
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [4:0]        key_code,
  input  logic [DATA_W-1:0] dato,
  input  logic              alu_done,
  output logic              shift_en,
  output logic              shift_clr,
  output logic [4:0]        digit_out,
  output logic [DATA_W-1:0] opa,
  output logic [DATA_W-1:0] opb,
  output logic [2:0]        opcode,
  output logic              alu_start,
  output logic [2:0]        state,
  output logic [2:0]        digit_cnt,
  output logic              err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_digit_cnt;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  opcode_t           r_opcode;
  logic              r_alu_start;
  logic              r_err;
  logic [4:0]        r_tmo_cnt;

  logic w_clear;
  logic w_enter;
  logic w_digit;
  logic w_op;
  logic w_entry;
  logic w_shift;
  logic w_tmo_hit;

  assign w_clear   = key_valid && (key_code == KEY_CLEAR);
  assign w_enter   = key_valid && (key_code == KEY_ENTER);
  assign w_digit   = key_valid && is_digit(key_code);
  assign w_op      = key_valid && is_op(key_code);
  assign w_entry   = (r_state == ST_ENTER_A) || (r_state == ST_ENTER_B);
  assign w_shift   = w_digit && w_entry && (r_digit_cnt < MAX_DIGITS);
  // True on the EXEC cycle that would complete the timeout window.
  assign w_tmo_hit = ((r_tmo_cnt + 5'd1) == TIMEOUT_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_ENTER_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ENTER_A:  if (w_enter) w_state_nxt = ST_ENTER_B;
      ST_ENTER_B:  if (w_enter) w_state_nxt = ST_ENTER_OP;
      ST_ENTER_OP: if (w_op)    w_state_nxt = ST_EXEC;
      ST_EXEC:     if (alu_done || w_tmo_hit) w_state_nxt = ST_SHOW;
      ST_SHOW:     if (w_enter) w_state_nxt = ST_ENTER_A;
      default:     w_state_nxt = ST_ENTER_A;
    endcase
    if (w_clear) w_state_nxt = ST_ENTER_A;
  end

  // Shift-register strobes are combinational so they land in the key cycle.
  always_comb begin
    shift_en  = 1'b0;
    shift_clr = 1'b1;
    if (rst) begin
      shift_en  = w_shift;
      shift_clr = w_clear || (w_enter && w_entry);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit_cnt <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_opcode    <= OP_K0;
      r_alu_start <= 1'b0;
      r_err       <= 1'b0;
      r_tmo_cnt   <= '0;
    end else if (w_clear) begin
      r_digit_cnt <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_opcode    <= OP_K0;
      r_alu_start <= 1'b0;
      r_err       <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_alu_start <= 1'b0;
      case (r_state)
        ST_ENTER_A, ST_ENTER_B: begin
          if (w_shift) begin
            r_digit_cnt <= r_digit_cnt + 3'd1;
          end else if (w_enter) begin
            r_digit_cnt <= '0;
            if (r_state == ST_ENTER_A) r_opa <= dato;
            else                       r_opb <= dato;
          end
        end
        ST_ENTER_OP: begin
          if (w_op) begin
            r_opcode    <= key_to_opcode(key_code);
            r_alu_start <= 1'b1;
            r_tmo_cnt   <= '0;
          end
        end
        ST_EXEC: begin
          // A result arriving on the last window cycle still wins over timeout.
          if (alu_done) begin
            r_tmo_cnt <= '0;
          end else if (w_tmo_hit) begin
            r_err     <= 1'b1;
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 5'd1;
          end
        end
        ST_SHOW: begin
          if (w_enter) r_err <= 1'b0;
        end
        default: begin
          r_tmo_cnt <= '0;
        end
      endcase
    end
  end

  assign digit_out = key_code;
  assign opa       = r_opa;
  assign opb       = r_opb;
  assign opcode    = r_opcode;
  assign alu_start = r_alu_start;
  assign state     = r_state;
  assign digit_cnt = r_digit_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed scenarios plus random key streams
// checked against a key-by-key behavioural model of the calculator.
module tb_calc_entry_ctrl;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = 5'h0;
  logic [15:0] dato = 16'h0;
  logic        alu_done = 1'b0;
  logic        shift_en, shift_clr, alu_start, err;
  logic [4:0]  digit_out;
  logic [15:0] opa, opb;
  logic [2:0]  opcode, state, digit_cnt;

  calc_entry_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .dato(dato), .alu_done(alu_done), .shift_en(shift_en), .shift_clr(shift_clr),
    .digit_out(digit_out), .opa(opa), .opb(opb), .opcode(opcode),
    .alu_start(alu_start), .state(state), .digit_cnt(digit_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: operands, the external shift register it feeds, and EXEC age.
  state_t      m_state;
  logic [15:0] m_opa, m_opb, m_sr;
  logic [2:0]  m_opc, m_ndig;
  logic        m_err;
  int          m_age;

  logic       obs_en, obs_clr, exp_en, exp_clr;
  logic [4:0] obs_dig;

  function automatic logic m_in_entry();
    return (m_state == ST_ENTER_A) || (m_state == ST_ENTER_B);
  endfunction

  function automatic logic m_alu_start();
    return (m_state == ST_EXEC) && (m_age == 0);
  endfunction

  task automatic model_reset();
    m_state = ST_ENTER_A; m_opa = 0; m_opb = 0; m_sr = 0;
    m_opc = 0; m_ndig = 0; m_err = 0; m_age = 0;
  endtask

  task automatic model_edge(input logic kv, input logic [4:0] kc, input logic done);
    if (kv && kc == 5'h11) begin
      model_reset();
    end else begin
      case (m_state)
        ST_ENTER_A, ST_ENTER_B: begin
          if (kv && kc <= 5'h0F) begin
            if (m_ndig < 3'd4) begin
              m_ndig = m_ndig + 3'd1;
              m_sr = {m_sr[11:0], kc[3:0]};
            end
          end else if (kv && kc == 5'h10) begin
            if (m_state == ST_ENTER_A) begin m_opa = m_sr; m_state = ST_ENTER_B; end
            else begin m_opb = m_sr; m_state = ST_ENTER_OP; end
            m_sr = 0; m_ndig = 0;
          end
        end
        ST_ENTER_OP: if (kv && kc >= 5'h12 && kc <= 5'h16) begin
          m_opc = 3'(kc - 5'h12); m_state = ST_EXEC; m_age = 0;
        end
        ST_EXEC: begin
          if (done) m_state = ST_SHOW;
          else if (m_age + 1 == 16) begin m_err = 1; m_state = ST_SHOW; end
          else m_age = m_age + 1;
        end
        ST_SHOW: if (kv && kc == 5'h10) begin m_state = ST_ENTER_A; m_err = 0; end
        default: m_state = ST_ENTER_A;
      endcase
    end
  endtask

  // One clock cycle: inputs applied after the falling edge, strobes captured
  // mid-cycle, model advanced on the rising edge, return 1 time unit later.
  task automatic step(input logic kv, input logic [4:0] kc, input logic done);
    @(negedge clk);
    key_valid = kv; key_code = kc; alu_done = done; dato = m_sr;
    #1;
    obs_en = shift_en; obs_clr = shift_clr; obs_dig = digit_out;
    exp_en  = kv && (kc <= 5'h0F) && m_in_entry() && (m_ndig < 3'd4);
    exp_clr = kv && (kc == 5'h11 || (kc == 5'h10 && m_in_entry()));
    @(posedge clk);
    model_edge(kv, kc, done);
    #1;
    key_valid = 1'b0; alu_done = 1'b0;
  endtask

  task automatic press(input logic [4:0] kc);
    step(1'b1, kc, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; #1; rst = 1'b0; key_valid = 1'b1; key_code = 5'h3; #1;
    n_vec++; if (state !== ST_ENTER_A) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state, ST_ENTER_A); end
    n_vec++; if (opa !== 16'h0 || opb !== 16'h0) begin n_err++; $display("FAIL reset_operands: got %h/%h want 0/0", opa, opb); end
    n_vec++; if (opcode !== 3'd0 || digit_cnt !== 3'd0) begin n_err++; $display("FAIL reset_op_cnt: got %0d/%0d want 0/0", opcode, digit_cnt); end
    n_vec++; if (err !== 1'b0 || alu_start !== 1'b0) begin n_err++; $display("FAIL reset_err_start: got %b/%b want 0/0", err, alu_start); end
    n_vec++; if (shift_en !== 1'b0 || shift_clr !== 1'b1) begin n_err++; $display("FAIL reset_strobes: got en=%b clr=%b want 0/1", shift_en, shift_clr); end
    @(posedge clk); #1;
    n_vec++; if (shift_en !== 1'b0 || shift_clr !== 1'b1 || digit_cnt !== 3'd0) begin n_err++; $display("FAIL reset_held: got en=%b clr=%b cnt=%0d", shift_en, shift_clr, digit_cnt); end
    key_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    model_reset();
  endtask

  task automatic test_entry();
    logic [4:0] keys [4] = '{5'h1, 5'h2, 5'hA, 5'hF};
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin press(keys[i]); if (obs_en === 1'b1) pulses++; end
    press(5'h10);
    n_vec++; if (pulses != 4) begin n_err++; $display("FAIL entry_pulses: got %0d want 4", pulses); end
    n_vec++; if (obs_clr !== 1'b1) begin n_err++; $display("FAIL entry_clr: got %b want 1", obs_clr); end
    n_vec++; if (opa !== 16'h12AF) begin n_err++; $display("FAIL entry_opa: got %h want 12af", opa); end
    n_vec++; if (state !== ST_ENTER_B || digit_cnt !== 3'd0) begin n_err++; $display("FAIL entry_state: got %0d cnt %0d want %0d cnt 0", state, digit_cnt, ST_ENTER_B); end
  endtask

  task automatic test_digit_limit();
    int pulses = 0;
    press(5'h11);
    for (int i = 1; i <= 5; i++) begin
      press(5'(i));
      if (i < 5 && obs_en === 1'b1) pulses++;
    end
    n_vec++; if (obs_en !== 1'b0) begin n_err++; $display("FAIL limit_fifth_en: got %b want 0", obs_en); end
    n_vec++; if (digit_cnt !== 3'd4 || pulses != 4) begin n_err++; $display("FAIL limit_cnt: got cnt %0d pulses %0d want 4/4", digit_cnt, pulses); end
    press(5'h10);
    n_vec++; if (opa !== 16'h1234) begin n_err++; $display("FAIL limit_opa: got %h want 1234", opa); end
  endtask

  task automatic test_exec();
    int starts = 0;
    press(5'h11); press(5'h3); press(5'h10); press(5'h4); press(5'h10); press(5'h12);
    n_vec++; if (state !== ST_EXEC || alu_start !== 1'b1) begin n_err++; $display("FAIL exec_start: got st %0d start %b want %0d/1", state, alu_start, ST_EXEC); end
    if (alu_start === 1'b1) starts++;
    for (int i = 0; i < 3; i++) begin step(1'b0, 5'h0, 1'b0); if (alu_start === 1'b1) starts++; end
    step(1'b0, 5'h0, 1'b1);
    if (alu_start === 1'b1) starts++;
    n_vec++; if (starts != 1) begin n_err++; $display("FAIL exec_start_width: got %0d cycles want 1", starts); end
    n_vec++; if (state !== ST_SHOW || err !== 1'b0) begin n_err++; $display("FAIL exec_show: got st %0d err %b want %0d/0", state, err, ST_SHOW); end
    n_vec++; if (opa !== 16'h3 || opb !== 16'h4 || opcode !== 3'd0) begin n_err++; $display("FAIL exec_latch: got %h %h %0d want 3 4 0", opa, opb, opcode); end
    press(5'h10);
    n_vec++; if (state !== ST_ENTER_A || opa !== 16'h3) begin n_err++; $display("FAIL show_exit: got st %0d opa %h want %0d/3", state, opa, ST_ENTER_A); end
  endtask

  task automatic test_timeout();
    int cycles = 0;
    logic [4:0] kc;
    press(5'h10); press(5'h10); press(5'h16);
    while (state === ST_EXEC && cycles < 40) begin
      kc = 5'($urandom_range(0, 31));
      if (kc == 5'h11) kc = 5'h10;
      step(1'($urandom_range(0, 1)), kc, 1'b0);
      cycles++;
    end
    n_vec++; if (cycles != 16) begin n_err++; $display("FAIL timeout_cycles: got %0d want 16", cycles); end
    n_vec++; if (state !== ST_SHOW || err !== 1'b1 || opcode !== 3'd4) begin n_err++; $display("FAIL timeout_show: got st %0d err %b op %0d want %0d/1/4", state, err, opcode, ST_SHOW); end
    press(5'h5);
    n_vec++; if (state !== ST_SHOW || err !== 1'b1) begin n_err++; $display("FAIL show_ignore: got st %0d err %b", state, err); end
    press(5'h10);
    n_vec++; if (state !== ST_ENTER_A || err !== 1'b0) begin n_err++; $display("FAIL show_err_clear: got st %0d err %b", state, err); end
  endtask

  task automatic test_clear();
    press(5'h5); press(5'h10); press(5'h1); press(5'h2);
    n_vec++; if (state !== ST_ENTER_B || digit_cnt !== 3'd2) begin n_err++; $display("FAIL clear_setup: got st %0d cnt %0d", state, digit_cnt); end
    press(5'h11);
    n_vec++; if (obs_clr !== 1'b1) begin n_err++; $display("FAIL clear_strobe: got %b want 1", obs_clr); end
    n_vec++; if (state !== ST_ENTER_A || opa !== 16'h0 || digit_cnt !== 3'd0) begin n_err++; $display("FAIL clear_state: got st %0d opa %h cnt %0d", state, opa, digit_cnt); end
  endtask

  task automatic test_reset_exec();
    int late_starts = 0;
    press(5'h7); press(5'h10); press(5'h8); press(5'h10); press(5'h13);
    n_vec++; if (state !== ST_EXEC || alu_start !== 1'b1) begin n_err++; $display("FAIL rexec_setup: got st %0d start %b", state, alu_start); end
    #2; rst = 1'b0; #1;
    n_vec++; if (state !== ST_ENTER_A || alu_start !== 1'b0) begin n_err++; $display("FAIL rexec_async: got st %0d start %b want %0d/0", state, alu_start, ST_ENTER_A); end
    n_vec++; if (opa !== 16'h0 || opb !== 16'h0 || opcode !== 3'd0 || err !== 1'b0 || digit_cnt !== 3'd0) begin n_err++; $display("FAIL rexec_regs: got %h %h %0d %b %0d", opa, opb, opcode, err, digit_cnt); end
    n_vec++; if (shift_en !== 1'b0 || shift_clr !== 1'b1) begin n_err++; $display("FAIL rexec_strobes: got en=%b clr=%b", shift_en, shift_clr); end
    model_reset();
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin step(1'b0, 5'h0, 1'b1); if (alu_start !== 1'b0 || state !== ST_ENTER_A) late_starts++; end
    n_vec++; if (late_starts != 0) begin n_err++; $display("FAIL rexec_release: got %0d bad cycles want 0", late_starts); end
  endtask

  task automatic test_random();
    logic kv, done;
    logic [4:0] kc;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      kv = 1'b1;
      if (r < 45)      kc = 5'($urandom_range(0, 15));
      else if (r < 60) kc = 5'h10;
      else if (r < 72) kc = 5'($urandom_range(18, 22));
      else if (r < 76) kc = 5'h11;
      else if (r < 84) kc = 5'($urandom_range(23, 31));
      else begin kv = 1'b0; kc = 5'($urandom_range(0, 31)); end
      done = ($urandom_range(0, 11) == 0);
      step(kv, kc, done);
      n_vec++; if (obs_en !== exp_en || obs_clr !== exp_clr || obs_dig !== kc) begin n_err++; $display("FAIL rnd_strobes[%0d]: got en=%b clr=%b dig=%h want %b/%b/%h", n, obs_en, obs_clr, obs_dig, exp_en, exp_clr, kc); end
      n_vec++; if (state !== m_state || digit_cnt !== m_ndig) begin n_err++; $display("FAIL rnd_state[%0d]: got st %0d cnt %0d want %0d/%0d", n, state, digit_cnt, m_state, m_ndig); end
      n_vec++; if (opa !== m_opa || opb !== m_opb || opcode !== m_opc) begin n_err++; $display("FAIL rnd_latch[%0d]: got %h %h %0d want %h %h %0d", n, opa, opb, opcode, m_opa, m_opb, m_opc); end
      n_vec++; if (err !== m_err || alu_start !== m_alu_start()) begin n_err++; $display("FAIL rnd_exec[%0d]: got err %b start %b want %b/%b", n, err, alu_start, m_err, m_alu_start()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_entry();
    test_digit_limit();
    test_exec();
    test_timeout();
    test_clear();
    test_reset_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

endmodule
